// File: rtl/rf_sched_pkg.sv
// Shared types and constants for the register-file write-port scheduler.
// R8 belongs to the input port; R9/R10 hold the saved PC (low/high half).
package rf_sched_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 4;
  localparam int PC_W   = 32;

  typedef enum logic {
    IDLE,
    SAVE_HI
  } state_t;

  localparam logic [ADDR_W-1:0] INPORT_REG = 4'd8;
  localparam logic [ADDR_W-1:0] PC_LO_REG  = 4'd9;
  localparam logic [ADDR_W-1:0] PC_HI_REG  = 4'd10;

  function automatic logic is_inport(input logic [ADDR_W-1:0] addr);
    return addr == INPORT_REG;
  endfunction

endpackage

// File: rtl/rf_write_sched_if.sv
// Write-back request streams, PC-save request and register-file write port.
// Handshake: a transfer happens in a cycle where valid && ready; ready never
// looks at the same source's valid, and valid stays up until its transfer.
interface rf_write_sched_if;
  import rf_sched_pkg::*;

  logic              alu_valid;
  logic              alu_ready;
  logic [ADDR_W-1:0] alu_addr;
  logic [DATA_W-1:0] alu_data;
  logic              mem_valid;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic              pc_save_req;
  logic [PC_W-1:0]   pc_value;
  logic              pc_save_ack;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic              ro_err;
  logic              busy;
  state_t            state;

  modport master (
    output alu_valid, alu_addr, alu_data,
    output mem_valid, mem_addr, mem_data,
    output pc_save_req, pc_value,
    input  alu_ready, mem_ready, pc_save_ack,
    input  rf_we, rf_waddr, rf_wdata, ro_err, busy, state
  );

  modport slave (
    input  alu_valid, alu_addr, alu_data,
    input  mem_valid, mem_addr, mem_data,
    input  pc_save_req, pc_value,
    output alu_ready, mem_ready, pc_save_ack,
    output rf_we, rf_waddr, rf_wdata, ro_err, busy, state
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; bit 0 = ALU, bit 1 = MEM.
// A grant bit depends only on the other requester and the pointer.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic       advance_i,
  output logic [1:0] grant_o
);

  logic rr_q;
  logic rr_d;
  logic [1:0] won;

  assign grant_o[0] = (rr_q == 1'b0) || !req_i[1];
  assign grant_o[1] = (rr_q == 1'b1) || !req_i[0];
  assign won        = req_i & grant_o;

  always_comb begin
    rr_d = rr_q;
    if (advance_i && won[0]) begin
      rr_d = 1'b1;
    end else if (advance_i && won[1]) begin
      rr_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q <= 1'b0;
    end else begin
      rr_q <= rr_d;
    end
  end

endmodule

// File: rtl/rf_write_sched.sv
// Shares the register file's single write port between ALU write-back,
// load write-back and the two-cycle PC save into R10:R9.
module rf_write_sched
  import rf_sched_pkg::*;
(
  input logic            clk,
  input logic            rst,
  rf_write_sched_if.slave bus
);

  state_t            state_q;
  logic              rf_we_q;
  logic [ADDR_W-1:0] rf_waddr_q;
  logic [DATA_W-1:0] rf_wdata_q;
  logic [DATA_W-1:0] hi_buf_q;
  logic              ro_err_q;

  logic [1:0]        grant;
  logic              stream_open;
  logic              alu_hs;
  logic              mem_hs;
  logic [ADDR_W-1:0] src_addr_d;
  logic [DATA_W-1:0] src_data_d;

  // Streams are only offered the port in IDLE with no pending PC save.
  assign stream_open = !rst && (state_q == IDLE) && !bus.pc_save_req;

  rr_arb2 u_arb (
    .clk       (clk),
    .rst       (rst),
    .req_i     ({bus.mem_valid, bus.alu_valid}),
    .advance_i (stream_open),
    .grant_o   (grant)
  );

  assign bus.alu_ready = stream_open && grant[0];
  assign bus.mem_ready = stream_open && grant[1];
  assign alu_hs        = bus.alu_valid && bus.alu_ready;
  assign mem_hs        = bus.mem_valid && bus.mem_ready;

  always_comb begin
    src_addr_d = bus.mem_addr;
    src_data_d = bus.mem_data;
    if (alu_hs) begin
      src_addr_d = bus.alu_addr;
      src_data_d = bus.alu_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      hi_buf_q   <= '0;
      ro_err_q   <= 1'b0;
    end else begin
      ro_err_q <= 1'b0;
      rf_we_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.pc_save_req) begin
            hi_buf_q   <= bus.pc_value[PC_W-1:DATA_W];
            rf_we_q    <= 1'b1;
            rf_waddr_q <= PC_LO_REG;
            rf_wdata_q <= bus.pc_value[DATA_W-1:0];
            state_q    <= SAVE_HI;
          end else if (alu_hs || mem_hs) begin
            // R8 writes are swallowed: the handshake completes, the port idles.
            if (is_inport(src_addr_d)) begin
              ro_err_q <= 1'b1;
            end else begin
              rf_we_q    <= 1'b1;
              rf_waddr_q <= src_addr_d;
              rf_wdata_q <= src_data_d;
            end
          end
        end
        SAVE_HI: begin
          rf_we_q    <= 1'b1;
          rf_waddr_q <= PC_HI_REG;
          rf_wdata_q <= hi_buf_q;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.pc_save_ack = !rst && (state_q == SAVE_HI);
  assign bus.rf_we       = rf_we_q;
  assign bus.rf_waddr    = rf_waddr_q;
  assign bus.rf_wdata    = rf_wdata_q;
  assign bus.ro_err      = ro_err_q;
  assign bus.busy        = (state_q != IDLE) || rf_we_q;
  assign bus.state       = state_q;

endmodule

// File: tb/tb_rf_write_sched.sv
// Directed bench for rf_write_sched: the driver pushes hand-computed write-port
// events into a queue, a negedge monitor pops and compares each observed event.
module tb_rf_write_sched;
  import rf_sched_pkg::*;

  localparam int W = 23;  // {we, ro_err, ack, addr[3:0], data[15:0]}

  logic clk;
  logic rst;
  rf_write_sched_if bus ();

  rf_write_sched dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [W-1:0] exp_q[$];
  int tests;
  int fails;
  logic [W-1:0] mon_got;
  logic [W-1:0] mon_exp;

  function automatic logic [W-1:0] ent(input logic we, input logic err, input logic ack,
                                       input logic [3:0] a, input logic [15:0] d);
    return {we, err, ack, a, d};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (bus.rf_we || bus.ro_err || bus.pc_save_ack) begin
      mon_got = {bus.rf_we, bus.ro_err, bus.pc_save_ack, bus.rf_waddr, bus.rf_wdata};
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_event: got %h expected none at %0t", mon_got, $time);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_exp[22] ? (mon_got !== mon_exp) : (mon_got[22:20] !== mon_exp[22:20])) begin
          fails++;
          $display("FAIL write_event: got %h expected %h at %0t", mon_got, mon_exp, $time);
        end
      end
    end
  end

  // driver
  initial begin
    int ai;
    int mi;
    logic alu_win;
    tests = 0;
    fails = 0;
    ai = 0;
    mi = 0;
    rst = 1'b1;
    bus.alu_valid = 1'b1;
    bus.alu_addr = 4'd1;
    bus.alu_data = 16'h0;
    bus.mem_valid = 1'b1;
    bus.mem_addr = 4'd2;
    bus.mem_data = 16'h0;
    bus.pc_save_req = 1'b0;
    bus.pc_value = 32'h0;

    repeat (3) tick();
    @(negedge clk);
    check("rst_alu_ready", 32'(bus.alu_ready), 32'd0);
    check("rst_mem_ready", 32'(bus.mem_ready), 32'd0);
    check("rst_rf_we", 32'(bus.rf_we), 32'd0);
    check("rst_waddr", 32'(bus.rf_waddr), 32'd0);
    check("rst_wdata", 32'(bus.rf_wdata), 32'd0);
    check("rst_ro_err", 32'(bus.ro_err), 32'd0);
    check("rst_ack", 32'(bus.pc_save_ack), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_state", 32'(bus.state), 32'(IDLE));
    tick();
    rst = 1'b0;
    bus.alu_valid = 1'b0;
    bus.mem_valid = 1'b0;

    // contention: ALU, MEM, ALU, MEM, then a lone ALU drains its last item
    for (int c = 0; c < 5; c++) begin
      bus.alu_valid = 1'b1;
      bus.alu_addr = 4'(1 + ai);
      bus.alu_data = 16'(16'hA000 + ai);
      bus.mem_valid = (c < 4);
      bus.mem_addr = 4'(4 + mi);
      bus.mem_data = 16'(16'hB000 + mi);
      alu_win = (c % 2 == 0);
      if (alu_win) begin
        exp_q.push_back(ent(1'b1, 1'b0, 1'b0, 4'(1 + ai), 16'(16'hA000 + ai)));
        ai++;
      end else begin
        exp_q.push_back(ent(1'b1, 1'b0, 1'b0, 4'(4 + mi), 16'(16'hB000 + mi)));
        mi++;
      end
      @(negedge clk);
      check("contend_alu_ready", 32'(bus.alu_ready), 32'(alu_win));
      check("contend_mem_ready", 32'(bus.mem_ready), 32'(!alu_win));
      tick();
    end
    bus.alu_valid = 1'b0;
    bus.mem_valid = 1'b0;
    tick();

    // ALU only
    bus.alu_valid = 1'b1;
    bus.alu_addr = 4'd3;
    bus.alu_data = 16'h1234;
    exp_q.push_back(ent(1'b1, 1'b0, 1'b0, 4'd3, 16'h1234));
    @(negedge clk);
    check("alu_only_ready", 32'(bus.alu_ready), 32'd1);
    tick();
    bus.alu_valid = 1'b0;
    @(negedge clk);
    check("alu_only_busy", 32'(bus.busy), 32'd1);
    tick();

    // PC save racing an ALU request
    bus.pc_save_req = 1'b1;
    bus.pc_value = 32'hDEAD_BEEF;
    bus.alu_valid = 1'b1;
    bus.alu_addr = 4'd6;
    bus.alu_data = 16'h5555;
    exp_q.push_back(ent(1'b1, 1'b0, 1'b1, 4'd9, 16'hBEEF));
    exp_q.push_back(ent(1'b1, 1'b0, 1'b0, 4'd10, 16'hDEAD));
    exp_q.push_back(ent(1'b1, 1'b0, 1'b0, 4'd6, 16'h5555));
    @(negedge clk);
    check("save_n_alu_ready", 32'(bus.alu_ready), 32'd0);
    check("save_n_ack", 32'(bus.pc_save_ack), 32'd0);
    tick();
    bus.pc_save_req = 1'b0;
    @(negedge clk);
    check("save_n1_alu_ready", 32'(bus.alu_ready), 32'd0);
    check("save_n1_ack", 32'(bus.pc_save_ack), 32'd1);
    check("save_n1_state", 32'(bus.state), 32'(SAVE_HI));
    check("save_n1_busy", 32'(bus.busy), 32'd1);
    tick();
    @(negedge clk);
    check("save_n2_alu_ready", 32'(bus.alu_ready), 32'd1);
    tick();
    bus.alu_valid = 1'b0;
    tick();

    // R8 write is dropped with an error pulse
    bus.mem_valid = 1'b1;
    bus.mem_addr = 4'd8;
    bus.mem_data = 16'h00FF;
    exp_q.push_back(ent(1'b0, 1'b1, 1'b0, 4'd0, 16'h0));
    @(negedge clk);
    check("r8_mem_ready", 32'(bus.mem_ready), 32'd1);
    tick();
    bus.mem_valid = 1'b0;
    @(negedge clk);
    check("r8_rf_we", 32'(bus.rf_we), 32'd0);
    check("r8_ro_err", 32'(bus.ro_err), 32'd1);
    tick();
    @(negedge clk);
    check("r8_ro_err_pulse", 32'(bus.ro_err), 32'd0);
    tick();

    // reset lands in SAVE_HI: R9 stands, R10 and ack never appear
    bus.pc_save_req = 1'b1;
    bus.pc_value = 32'h7777_1111;
    exp_q.push_back(ent(1'b1, 1'b0, 1'b0, 4'd9, 16'h1111));
    tick();
    bus.pc_save_req = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("rst_save_ack", 32'(bus.pc_save_ack), 32'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_rf_we", 32'(bus.rf_we), 32'd0);
    check("post_rst_waddr", 32'(bus.rf_waddr), 32'd0);
    check("post_rst_wdata", 32'(bus.rf_wdata), 32'd0);
    check("post_rst_busy", 32'(bus.busy), 32'd0);
    check("post_rst_state", 32'(bus.state), 32'(IDLE));
    repeat (2) tick();

    // request held four cycles: two complete saves, new PC sampled for the second
    bus.pc_save_req = 1'b1;
    bus.pc_value = 32'h1234_5678;
    exp_q.push_back(ent(1'b1, 1'b0, 1'b1, 4'd9, 16'h5678));
    exp_q.push_back(ent(1'b1, 1'b0, 1'b0, 4'd10, 16'h1234));
    exp_q.push_back(ent(1'b1, 1'b0, 1'b1, 4'd9, 16'hF00D));
    exp_q.push_back(ent(1'b1, 1'b0, 1'b0, 4'd10, 16'hCAFE));
    repeat (2) tick();
    bus.pc_value = 32'hCAFE_F00D;
    repeat (2) tick();
    bus.pc_save_req = 1'b0;
    repeat (4) tick();

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rf_write_sched.md
# rf_write_sched

Write-port scheduler for the 16×16-bit register file. Shares the file's single write port between the ALU write-back stream, the memory/load write-back stream and the PC-save sequencer. The PC-save sequencer splits a 32-bit PC into the two private registers R9/R10 on call/interrupt entry. Sits between the write-back stage and the register file's write_enable/write_addr/write_data inputs.

## Interface
- DATA_W, 16, register width
- ADDR_W, 4, register address width
- PC_W, 32, program counter width (must equal 2*DATA_W)
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- alu_valid / alu_ready  in / out  1  ALU write request handshake
- alu_addr  in  ADDR_W  ALU destination register
- alu_data  in  DATA_W  ALU result
- mem_valid / mem_ready  in / out  1  load write request handshake
- mem_addr  in  ADDR_W  load destination register
- mem_data  in  DATA_W  load data
- pc_save_req  in  1  level request to store pc_value into R10:R9
- pc_value  in  PC_W  PC to save, sampled when the request is taken
- pc_save_ack  out  1  high during the cycle the high half is issued
- rf_we  out  1  register file write enable (registered)
- rf_waddr  out  ADDR_W  register file write address (registered)
- rf_wdata  out  DATA_W  register file write data (registered)
- ro_err  out  1  one-cycle pulse: accepted write targeted R8 and was dropped
- busy  out  1  (state != IDLE) || rf_we

## Operation
- FSM states: IDLE, SAVE_HI.
- IDLE with pc_save_req=1:
  - Highest priority; alu_ready = mem_ready = 0.
  - Latch pc_value[31:16] into hi_buf.
  - Register rf_we=1, rf_waddr=9, rf_wdata=pc_value[15:0].
  - Transition to SAVE_HI.
- SAVE_HI:
  - pc_save_ack=1 (combinational from state); both readies 0.
  - Register rf_we=1, rf_waddr=10, rf_wdata=hi_buf.
  - Return to IDLE unconditionally.
- IDLE, no save request:
  - 2-way round-robin between ALU and MEM.
  - Pointer rr=0 prefers ALU, rr=1 prefers MEM.
  - Only the selected requester sees ready=1. A lone valid requester is always selected.
  - After each handshake, rr points away from the granted source.
- Accepted handshake (valid && ready) registers rf_we=1 with that source's addr/data.
  - Exception, addr == 8 (inport-owned R8): rf_we=0 next cycle, ro_err=1 for one cycle. The handshake still completes, so the requester never stalls.
- No accepted request and no save activity: rf_we=0. rf_waddr and rf_wdata hold their last value.
- ready never depends on the same source's valid. valid may drop only after its handshake.

## Timing
- Reset values: state=IDLE, rf_we=0, rf_waddr=0, rf_wdata=0, rr=0, hi_buf=0, ro_err=0, pc_save_ack=0, busy=0, both readies 0 during rst.
- Write latency: handshake in cycle N gives rf_we high in cycle N+1. Throughput is one write per cycle.
- PC save, request first seen in IDLE at cycle N:
  - R9 write visible at N+1.
  - R10 write visible at N+2.
  - pc_save_ack high at N+1.
  - Requester must drop pc_save_req by N+2. A request still high in IDLE at N+2 starts a new save.
- Simultaneous pc_save_req and alu/mem valid: save wins; streams stall exactly 2 cycles.
- Simultaneous alu_valid and mem_valid every cycle: grants strictly alternate.
- rst during SAVE_HI: the R10 write is abandoned and ack is not raised. The already-issued R9 write stands.

## Structure
- Package rf_sched_pkg: state enum {IDLE, SAVE_HI}; constants INPORT_REG=4'd8, PC_LO_REG=4'd9, PC_HI_REG=4'd10.
- Sub-module rr_arb2: req[1:0], advance → grant[1:0], owns the rr pointer, synchronous rst.
- The FSM, output registers and R8 filter stay in rf_write_sched.

## Test plan
- ALU only: alu_valid=1, addr=3, data=0x1234 at cycle 5 → alu_ready=1 at 5; rf_we=1, rf_waddr=3, rf_wdata=0x1234 at 6.
- Contention: alu and mem both valid for 4 cycles after reset → grants ALU, MEM, ALU, MEM; rf_we high 4 consecutive cycles.
- PC save: pc_save_req at cycle 10 with pc_value=0xDEAD_BEEF, alu_valid also high → writes R9=0xBEEF at 11 and R10=0xDEAD at 12; ack at 11; alu_ready=0 at 10–11, 1 at 12.
- R8 protection: mem_valid, addr=8, data=0x00FF → handshake completes; rf_we=0 and ro_err=1 next cycle.
- Reset mid-save: rst asserted in the SAVE_HI cycle → no R10 write, ack=0, all outputs at reset values next cycle.
- Back-to-back saves: pc_save_req held 4 cycles → R9/R10 pairs issued twice, with ack high at cycles 1 and 3 relative to the first request.
